// File: rtl/trigger_transmitter.sv
// Trigger transmitter: queues tagged trigger requests in a small FIFO and
// serializes each as a 3-bit frame (start bit, tag[1], tag[0]) on o_trig.
module trigger_transmitter #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_trig_req,
  input  logic            i_clr_err,
  output logic            o_trig,
  output logic            o_accept,
  output logic [1:0]      o_accept_tag,
  output logic            o_full,
  output logic            o_busy,
  output logic            o_overflow,
  output logic [CNTW-1:0] o_sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SB, S_B1, S_B0} state_t;

  state_t            r_state;
  logic [1:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_tag;
  logic [1:0]        r_shift;
  logic              r_trig;
  logic              r_accept;
  logic [1:0]        r_accept_tag;
  logic              r_full;
  logic              r_busy;
  logic              r_overflow;
  logic [CNTW-1:0]   r_sent_cnt;

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_reject;
  logic [CW-1:0]     w_count_nxt;

  // Full comes from the registered occupancy, so a same-edge pop never frees room for a push.
  assign w_empty  = (r_count == {CW{1'b0}});
  assign w_push   = i_trig_req & ~r_full & ~i_reset;
  assign w_reject = i_trig_req & r_full;
  assign w_pop    = ~w_empty & ((r_state == S_IDLE) | (r_state == S_B0));

  // Next FIFO occupancy from this edge's push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_tag;
    end
  end

  // FIFO pointers, occupancy and the derived Full/Busy flags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
      r_full  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_busy  <= (r_state == S_SB) | (r_state == S_B1) | ~w_empty |
                 (w_count_nxt != {CW{1'b0}});
    end
  end

  // Tag generator, accept handshake and sticky overflow (set beats clear).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tag        <= 2'b00;
      r_accept     <= 1'b0;
      r_accept_tag <= 2'b00;
      r_overflow   <= 1'b0;
    end else begin
      r_accept <= w_push;
      if (w_push) begin
        r_tag        <= r_tag + 2'd1;
        r_accept_tag <= r_tag;
      end
      if (w_reject)       r_overflow <= 1'b1;
      else if (i_clr_err) r_overflow <= 1'b0;
    end
  end

  // Serializer: o_trig is loaded with the bit belonging to the state being entered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_trig     <= 1'b0;
      r_shift    <= 2'b00;
      r_sent_cnt <= {CNTW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_SB;
            r_trig  <= 1'b1;
            r_shift <= r_mem[r_rptr];
          end else begin
            r_trig  <= 1'b0;
          end
        end
        S_SB: begin
          r_state <= S_B1;
          r_trig  <= r_shift[1];
        end
        S_B1: begin
          r_state <= S_B0;
          r_trig  <= r_shift[0];
        end
        S_B0: begin
          r_sent_cnt <= r_sent_cnt + CNTW'(1);
          if (!w_empty) begin
            r_state <= S_SB;
            r_trig  <= 1'b1;
            r_shift <= r_mem[r_rptr];
          end else begin
            r_state <= S_IDLE;
            r_trig  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_trig  <= 1'b0;
        end
      endcase
    end
  end

  assign o_trig       = r_trig;
  assign o_accept     = r_accept;
  assign o_accept_tag = r_accept_tag;
  assign o_full       = r_full;
  assign o_busy       = r_busy;
  assign o_overflow   = r_overflow;
  assign o_sent_cnt   = r_sent_cnt;

endmodule

// File: tb/tb_trigger_transmitter.sv
// Scoreboarded bench for trigger_transmitter: a queue-based frame model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_trigger_transmitter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        clr = 1'b0;
  logic        trig, acc, full, busy, ovf;
  logic [1:0]  acc_tag;
  logic [15:0] sent;
  logic        trig2, acc2, full2, busy2, ovf2;
  logic [1:0]  acc_tag2;
  logic [1:0]  sent2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit trig; bit acc; int tag; bit full; bit busy; bit ovf; int sent;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: pending tags, bits still to appear on the line, counters.
  int m_fifo[$];
  int m_bits[$];
  int m_tag  = 0;
  int m_sent = 0;
  bit m_ovf  = 1'b0;

  trigger_transmitter #(.DEPTH(DEPTH), .CNTW(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_trig_req(req), .i_clr_err(clr),
    .o_trig(trig), .o_accept(acc), .o_accept_tag(acc_tag), .o_full(full),
    .o_busy(busy), .o_overflow(ovf), .o_sent_cnt(sent));

  trigger_transmitter #(.DEPTH(DEPTH), .CNTW(2)) dut_w (
    .i_clock(clk), .i_reset(rst), .i_trig_req(req), .i_clr_err(clr),
    .o_trig(trig2), .o_accept(acc2), .o_accept_tag(acc_tag2), .o_full(full2),
    .o_busy(busy2), .o_overflow(ovf2), .o_sent_cnt(sent2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
  endtask

  task automatic model_edge(input bit r, input bit c, input bit rs);
    exp_t e;
    bit   full_b;
    int   t;
    e.acc = 1'b0;
    e.tag = 0;
    if (rs) begin
      m_fifo.delete();
      m_bits.delete();
      m_tag  = 0;
      m_sent = 0;
      m_ovf  = 1'b0;
    end else begin
      full_b = (m_fifo.size() == DEPTH);
      if (m_bits.size() > 0) begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) m_sent++;
      end
      if (m_bits.size() == 0 && m_fifo.size() > 0) begin
        t = m_fifo.pop_front();
        m_bits.push_back(1);
        m_bits.push_back((t >> 1) & 1);
        m_bits.push_back(t & 1);
      end
      if (r && !full_b) begin
        m_fifo.push_back(m_tag);
        e.acc = 1'b1;
        e.tag = m_tag;
        m_tag = (m_tag + 1) % 4;
      end
      if (r && full_b) m_ovf = 1'b1;
      else if (c)      m_ovf = 1'b0;
    end
    e.trig = (m_bits.size() > 0) ? (m_bits[0] != 0) : 1'b0;
    e.full = (m_fifo.size() == DEPTH);
    e.busy = (m_bits.size() > 0) || (m_fifo.size() > 0);
    e.ovf  = m_ovf;
    e.sent = m_sent;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit c, input bit rs);
    req = r;
    clr = c;
    rst = rs;
    @(posedge clk);
    model_edge(r, c, rs);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: each cycle's predicted outputs are compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("trig",     int'(trig),  int'(e.trig));
      chk("accept",   int'(acc),   int'(e.acc));
      if (e.acc) chk("accept_tag", int'(acc_tag), e.tag);
      chk("full",     int'(full),  int'(e.full));
      chk("busy",     int'(busy),  int'(e.busy));
      chk("overflow", int'(ovf),   int'(e.ovf));
      chk("sent_cnt", int'(sent),  e.sent % 65536);
      chk("sent_cnt_w2", int'(sent2), e.sent % 4);
    end
  end

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sent", int'(sent), 0);

    // Single pulse: Trig 0,1,0,0 follows from the accepting edge
    step(1'b1, 1'b0, 1'b0);
    chk("single_tag", int'(acc_tag), 0);
    chk("single_t0", int'(trig), 0);
    step(1'b0, 1'b0, 1'b0); chk("single_t1", int'(trig), 1);
    step(1'b0, 1'b0, 1'b0); chk("single_t2", int'(trig), 0);
    step(1'b0, 1'b0, 1'b0); chk("single_t3", int'(trig), 0);
    idle(3);
    chk("single_sent", int'(sent), 1);

    // Burst of four: tags 1,2,3,0 back to back
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    idle(16);
    chk("burst_sent", int'(sent), 5);
    chk("burst_busy", int'(busy), 0);

    // Overflow: 8 held requests from reset, 6 accepted
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    chk("ovf_set", int'(ovf), 1);
    idle(22);
    chk("ovf_sent", int'(sent), 6);
    step(1'b1, 1'b0, 1'b0);
    chk("ovf_next_tag", int'(acc_tag), 2);
    idle(6);

    // ClrErr coincident with a rejection: set wins
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_vs_reject", int'(ovf), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("clr_alone", int'(ovf), 0);
    idle(22);

    // Reset during B1 abandons the frame
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("midrst_trig", int'(trig), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sent", int'(sent), 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); chk("midrst_f0", int'(trig), 1);
    step(1'b0, 1'b0, 1'b0); chk("midrst_f1", int'(trig), 0);
    step(1'b0, 1'b0, 1'b0); chk("midrst_f2", int'(trig), 0);
    idle(3);

    // SentCnt wrap on the 2-bit instance: 5 frames -> 1
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    idle(24);
    chk("wrap_sent2", int'(sent2), 1);

    // Randomized traffic with occasional clear and reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 55), ($urandom_range(99) < 10),
           ($urandom_range(99) < 2));
    end
    idle(30);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_transmitter.md
TRIGGER_TRANSMITTER -- requirements
Module: trigger_transmitter

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO depth in entries; power of two, minimum 2.
REQ-002 Parameter CNTW, default 16: width of SentCnt.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 TrigReq  input  1  request one trigger frame; sampled every rising edge.
REQ-006 ClrErr  input  1  clears Overflow.
REQ-007 Trig  output  1  serial trigger line, registered.
REQ-008 Accept  output  1  one-cycle pulse; request accepted at the previous edge.
REQ-009 AcceptTag  output  2  tag assigned to the accepted request; valid while Accept=1.
REQ-010 Full  output  1  FIFO holds DEPTH entries.
REQ-011 Busy  output  1  FIFO non-empty or a frame in progress.
REQ-012 Overflow  output  1  sticky; a request was rejected.
REQ-013 SentCnt  output  CNTW  count of completed frames; wraps modulo 2^CNTW.

Function
REQ-014 Frame format on Trig: start bit 1, then Tag[1], then Tag[0]; one bit per clock; MSB first.
REQ-015 Frames are back-to-back with no idle bit when the FIFO is non-empty at the end of a frame; Trig=0 otherwise.
REQ-016 Tag generator: 2-bit counter; assigns its current value to each accepted request, then increments modulo 4.
REQ-017 Rejected requests do not consume a tag.
REQ-018 A request is accepted when TrigReq=1 and Full=0 at the edge; the entry is written with the assigned tag.
REQ-019 Full is evaluated from the occupancy before that edge; a pop at the same edge does not admit a push when full.
REQ-020 TrigReq=1 with Full=1 rejects the request and sets Overflow.
REQ-021 Overflow is cleared by ClrErr=1 at an edge with no rejection; if both occur at the same edge, set wins.
REQ-022 Serializer states, named by the Trig value they drive:
- IDLE (0)
- SB (1)
- B1 (tag[1])
- B0 (tag[0])
REQ-023 IDLE->SB when the FIFO is non-empty; pop the head into the tag shift register at that edge; else remain in IDLE.
REQ-024 SB->B1 and B1->B0 are unconditional.
REQ-025 B0->SB with a pop when the FIFO is non-empty; else B0->IDLE.
REQ-026 SentCnt increments at each edge leaving B0.
REQ-027 Latency: request accepted at edge N into an empty FIFO while in IDLE -> Trig=1 in the cycle after edge N+1.
REQ-028 A simultaneous push and pop leaves the occupancy unchanged; the FIFO read and write pointers wrap modulo DEPTH.
REQ-029 Busy=1 when the state is not IDLE or occupancy>0.
REQ-030 Accept and AcceptTag are registered, asserted in the cycle following the accepting edge.

Reset
REQ-031 Reset=1 at an edge forces the following, regardless of the current state (including mid-frame):
- state IDLE, Trig=0
- FIFO emptied
- tag counter 0
- Accept=0, AcceptTag=0, Full=0, Busy=0
- Overflow=0, SentCnt=0
REQ-032 A partial frame is abandoned at reset and is not completed or counted.
REQ-033 TrigReq is ignored at any edge where Reset=1.

Verification
REQ-034 The bench shall cover these directed scenarios:
- Single pulse: after reset, TrigReq=1 for one cycle -> Trig reads 0,1,0,0 from the accepting edge; AcceptTag=00; SentCnt=1.
- Burst of four: TrigReq=1 for 4 cycles -> contiguous Trig stream 100 101 110 111 with no gaps; SentCnt=4; Busy falls after the last bit.
- Overflow (DEPTH=4): TrigReq held for 8 cycles from IDLE -> 6 requests accepted with tags 0,1,2,3,0,1; 7th and 8th rejected; Overflow=1; 6 frames sent; next new request gets tag 2.
- ClrErr coincident with a rejection -> Overflow stays 1; ClrErr alone next cycle -> Overflow=0.
- Reset asserted during B1 -> Trig=0 next cycle, Busy=0, SentCnt=0; next request transmits 100.
- SentCnt wrap: CNTW=2, 5 frames -> SentCnt=1.
